// File: rtl/fetch_unit_pkg.sv
// Shared fetch-side types: PC/instruction words, fetch group width and queue entry layout.
package fetch_unit_pkg;

  localparam int unsigned FETCH_WIDTH = 4;

  typedef logic [31:0] PC;
  typedef logic [31:0] REG_WIDTH;

  typedef struct packed {
    PC        pc;
    REG_WIDTH inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_inst_queue.sv
// Circular instruction queue: up to FETCH_WIDTH pushes and one pop per cycle, with flush.
module fetch_unit_inst_queue
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1,
  localparam int unsigned NW    = $clog2(FETCH_WIDTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NW-1:0]                  push_n,
  input  fetch_entry_t [FETCH_WIDTH-1:0] push_data,
  input  logic                           pop,
  input  logic                           flush,
  output fetch_entry_t                   head,
  output logic [CW-1:0]                  count
);

  fetch_entry_t r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop = pop && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop);
      r_tail  <= r_tail + PW'(push_n);
      r_count <= r_count + CW'(push_n) - CW'(w_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      if (k < 32'(push_n)) r_mem[r_tail + PW'(k)] <= push_data[k];
    end
  end

  assign head  = r_mem[r_head];
  assign count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns the fetch PC, fills the instruction queue from the icache, issues to decode.
// Optional build macro FETCH_ALIGN_EN: fetch groups are 16-byte aligned.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter  int unsigned QUEUE_DEPTH = 16,
  parameter  PC           RESET_PC    = 32'hBFC0_0000,
  localparam int unsigned CW          = $clog2(QUEUE_DEPTH) + 1,
  localparam int unsigned NW          = $clog2(FETCH_WIDTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [31:0]                 ic_pc,
  input  logic [FETCH_WIDTH-1:0][31:0] ic_inst,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [31:0]                 dec_inst,
  output logic [31:0]                 dec_pc,
  output logic [CW-1:0]               q_count
);

  PC                              r_fetch_pc;
  logic [1:0]                     w_off;
  logic                           w_push_en;
  logic [NW-1:0]                  w_push_n;
  fetch_entry_t [FETCH_WIDTH-1:0] w_push_data;
  fetch_entry_t                   w_head;
  logic [CW-1:0]                  w_count;
  logic                           w_pop;

`ifdef FETCH_ALIGN_EN
  assign w_off = r_fetch_pc[3:2];
`else
  assign w_off = '0;
`endif

  // Threshold uses registered occupancy so a same-cycle pop never lets a push overflow.
  assign w_push_en = !redirect_valid && (w_count <= CW'(QUEUE_DEPTH - FETCH_WIDTH));
  assign w_push_n  = w_push_en ? (NW'(FETCH_WIDTH) - NW'(w_off)) : '0;

  // Entry k takes cache slot k+w_off; slots past the group end wrap but are never written.
  always_comb begin
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      w_push_data[k].pc   = r_fetch_pc + 32'(4 * k);
      w_push_data[k].inst = ic_inst[2'(k + 32'(w_off))];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_push_en) begin
      r_fetch_pc <= r_fetch_pc + 32'({w_push_n, 2'b00});
    end
  end

  assign w_pop = dec_valid && dec_ready;

  fetch_unit_inst_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_inst_queue (
    .clk      (clk),
    .rst      (rst),
    .push_n   (w_push_n),
    .push_data(w_push_data),
    .pop      (w_pop),
    .flush    (redirect_valid),
    .head     (w_head),
    .count    (w_count)
  );

  assign ic_pc     = r_fetch_pc;
  assign dec_valid = (w_count != '0);
  assign dec_inst  = dec_valid ? w_head.inst : '0;
  assign dec_pc    = dec_valid ? w_head.pc : '0;
  assign q_count   = w_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random redirects/ready against a queue-based model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 16;
`ifdef FETCH_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      ic_pc;
  logic [3:0][31:0] ic_inst;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             dec_valid;
  logic             dec_ready;
  logic [31:0]      dec_inst;
  logic [31:0]      dec_pc;
  logic [4:0]       q_count;

  fetch_unit #(
    .QUEUE_DEPTH(DEPTH),
    .RESET_PC   (32'hBFC0_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ic_pc         (ic_pc),
    .ic_inst       (ic_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc),
    .q_count       (q_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Icache model: aligned build returns the whole 16-byte line holding ic_pc.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (ALIGN) ic_inst[k] = imem({ic_pc[31:4], 4'h0} + 32'(4 * k));
      else       ic_inst[k] = imem(ic_pc + 32'(4 * k));
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  task automatic model_reset();
    mq.delete();
    m_pc = 32'hBFC0_0000;
  endtask

  task automatic model_edge(input logic rv, input logic [31:0] rpc, input logic rdy);
    int unsigned sz;
    int unsigned off;
    ent_t e;
    sz = mq.size();
    if (rdy && sz != 0) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
      m_pc = rpc;
    end else if (sz <= DEPTH - 4) begin
      off = ALIGN ? 32'(m_pc[3:2]) : 0;
      for (int unsigned k = off; k < 4; k++) begin
        e.pc   = m_pc + 4 * (k - off);
        e.inst = imem(e.pc);
        mq.push_back(e);
      end
      m_pc = m_pc + 4 * (4 - off);
    end
  endtask

  task automatic compare_all();
    check("ic_pc", ic_pc, m_pc);
    check("dec_valid", 32'(dec_valid), 32'(mq.size() != 0));
    check("q_count", 32'(q_count), 32'(mq.size()));
    check("dec_pc", dec_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
    check("dec_inst", dec_inst, (mq.size() != 0) ? mq[0].inst : 32'h0);
  endtask

  // Called at a negedge: drive inputs, take the edge, compare mid-cycle.
  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    @(posedge clk);
    model_edge(rv, rpc, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] exp_seq;

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check("reset_ic_pc", ic_pc, 32'hBFC0_0000);
    check("reset_dec_valid", 32'(dec_valid), 32'h0);
    check("reset_q_count", 32'(q_count), 32'h0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Fill with decode stalled
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, 1'b0);
      check("fill_count", 32'(q_count), (i < 4) ? 32'(4 * (i + 1)) : 32'd16);
    end
    check("fill_stall_pc", ic_pc, 32'hBFC0_0040);

    // Stream from reset with decode always ready
    do_reset();
    exp_seq = 32'hBFC0_0000;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, '0, 1'b1);
      check("stream_valid", 32'(dec_valid), 32'h1);
      if (dec_valid) begin
        check("stream_seq", dec_pc, exp_seq);
        exp_seq += 4;
      end
    end

    // Redirect during a pop
    cycle(1'b1, 32'h8000_0100, 1'b1);
    check("redir_count", 32'(q_count), 32'h0);
    check("redir_ic_pc", ic_pc, 32'h8000_0100);
    cycle(1'b0, '0, 1'b0);
    check("redir_dec_pc", dec_pc, 32'h8000_0100);
    check("redir_dec_valid", 32'(dec_valid), 32'h1);

    // Back-to-back redirects: last wins
    cycle(1'b1, 32'h1234_0000, 1'b0);
    cycle(1'b1, 32'h5678_0040, 1'b0);
    check("b2b_ic_pc", ic_pc, 32'h5678_0040);

    // PC wrap past 2^32 and queue pointer wrap
    cycle(1'b1, 32'hFFFF_FFF0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("wrap_ic_pc", ic_pc, 32'h0000_0000);
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'($urandom_range(0, 3) != 0));

    // Unaligned redirect target
    cycle(1'b1, 32'h8000_0108, 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("align_dec_pc", dec_pc, 32'h8000_0108);
`ifdef FETCH_ALIGN_EN
    check("align_count", 32'(q_count), 32'd2);
    check("align_ic_pc", ic_pc, 32'h8000_0110);
`else
    check("align_count", 32'(q_count), 32'd4);
    check("align_ic_pc", ic_pc, 32'h8000_0118);
`endif

    // Random traffic with occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 15) == 0), {$urandom(), 2'b00} >> 0,
              1'($urandom_range(0, 9) < 7));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
